// File: rtl/cr16_pkg.sv
// -----------------------------------------------------------------------------
// cr16_pkg
// Shared constants and types for the CR16 multiply unit.
//   mult_state_e : multiplier control FSM encoding (IDLE / RUN / DONE)
//   CR16_WORD    : CR16 data word width
//   MULT_ITERS   : shift-add iterations for one full-width multiply
// -----------------------------------------------------------------------------
package cr16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    localparam int CR16_WORD  = 16;
    localparam int MULT_ITERS = 16;

endpackage

// File: rtl/cr16_mult_unit.sv
// -----------------------------------------------------------------------------
// cr16_mult_unit
// Sequential WIDTH x WIDTH shift-add multiplier. One Start pulse in IDLE
// launches a multiply; the product appears one cycle-pulse of Done later and
// is held until the next multiply completes. The low product word feeds
// input 3 of the ALU B-operand mux.
//
// Optional feature: define CR16_MULT_SIGNED_EN to honour SignMode (signed
// two's-complement multiply via magnitudes and a final negation). Without the
// macro every multiply is unsigned and no negation logic is built.
//
// Ports:
//   Clk         in   rising-edge clock
//   Reset       in   synchronous, active-high reset
//   Start       in   launch request, sampled only in IDLE
//   SignMode    in   1 = signed multiply (only with CR16_MULT_SIGNED_EN)
//   OpA         in   multiplicand (Rsrc)
//   OpB         in   multiplier (Rdest)
//   Busy        out  high whenever the FSM is not in IDLE
//   Done        out  one-cycle pulse, product valid
//   ALUB_input3 out  product[WIDTH-1:0]
//   MultHi      out  product[2*WIDTH-1:WIDTH]
// -----------------------------------------------------------------------------
module cr16_mult_unit
    import cr16_pkg::*;
#(
    parameter int WIDTH = CR16_WORD
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             SignMode,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUB_input3,
    output logic [WIDTH-1:0] MultHi
);

    // One iteration per multiplier bit; the counter must also be able to
    // hold the terminal value ITERS, which marks "all iterations done".
    localparam int ITERS = WIDTH;
    localparam int CNT_W = $clog2(ITERS + 1);

    mult_state_e        state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;

    logic               iter_done;
    logic [WIDTH:0]     partial;      // carry bit + upper accumulator half
    logic [2*WIDTH-1:0] acc_shift;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] product;

    assign iter_done = (count_q == CNT_W'(ITERS));

    // -------------------------------------------------------------------------
    // Operand conditioning and final product correction
    // -------------------------------------------------------------------------
`ifdef CR16_MULT_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;

    assign a_neg   = SignMode & OpA[WIDTH-1];
    assign b_neg   = SignMode & OpB[WIDTH-1];
    // The most negative value maps onto itself, which is still the correct
    // unsigned magnitude 2^(WIDTH-1).
    assign a_mag   = a_neg ? (~OpA + 1'b1) : OpA;
    assign b_mag   = b_neg ? (~OpB + 1'b1) : OpB;
    assign product = neg_q ? (~acc_q + 1'b1) : acc_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            neg_q <= 1'b0;
        end else if (state_q == ST_IDLE && Start) begin
            neg_q <= a_neg ^ b_neg;
        end
    end
`else
    logic unused_sign_mode;

    assign unused_sign_mode = SignMode;
    assign a_mag            = OpA;
    assign b_mag            = OpB;
    assign product          = acc_q;
`endif

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is
        // inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (Start)     state_d = ST_RUN;
            ST_RUN:  if (iter_done) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Shift-add datapath
    // -------------------------------------------------------------------------
    always_comb begin
        partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (mplier_q[0]) begin
            partial = partial + {1'b0, mcand_q};
        end
    end

    // {carry, upper, lower} shifted right by one; the carry lands in the MSB.
    assign acc_shift = {partial, acc_q[WIDTH-1:1]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        acc_q    <= '0;
                        count_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (iter_done) begin
                        // Product is captured on the edge that enters DONE,
                        // so it is visible in the same cycle as Done.
                        lo_q <= product[WIDTH-1:0];
                        hi_q <= product[2*WIDTH-1:WIDTH];
                    end else begin
                        acc_q    <= acc_shift;
                        mplier_q <= mplier_q >> 1;
                        count_q  <= count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy        = (state_q != ST_IDLE);
    assign Done        = (state_q == ST_DONE);
    assign ALUB_input3 = lo_q;
    assign MultHi      = hi_q;

endmodule

// File: tb/tb_cr16_mult_unit.sv
// -----------------------------------------------------------------------------
// tb_cr16_mult_unit
// Directed self-checking bench for cr16_mult_unit. Inputs are driven and
// outputs sampled on the falling clock edge. Cycle k of a multiply is the
// cycle following edge E(k-1), where E0 is the edge that samples Start, so
// Done is expected in cycle 18 and Busy in cycles 1..18.
// Signed-mode expectations follow CR16_MULT_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_cr16_mult_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        SignMode;
    logic [15:0] OpA;
    logic [15:0] OpB;
    logic        Busy;
    logic        Done;
    logic [15:0] ALUB_input3;
    logic [15:0] MultHi;

    int total = 0;
    int bad   = 0;

    cr16_mult_unit #(.WIDTH(16)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .SignMode    (SignMode),
        .OpA         (OpA),
        .OpB         (OpB),
        .Busy        (Busy),
        .Done        (Done),
        .ALUB_input3 (ALUB_input3),
        .MultHi      (MultHi)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Launch one multiply and watch 26 cycles. extra_starts injects ignored
    // Start pulses at E5 and on the Done cycle (E18); reset_at > 0 asserts
    // Reset so that it is sampled at E(reset_at).
    task automatic run_mult(input logic [15:0] a, input logic [15:0] b,
                            input logic sm, input bit extra_starts,
                            input int reset_at,
                            output logic [15:0] lo, output logic [15:0] hi,
                            output logic [15:0] lo_k1, output logic [15:0] hi_k1,
                            output int busy_n, output int done_n,
                            output int done_at);
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        lo      = 16'h0;
        hi      = 16'h0;
        lo_k1   = 16'h0;
        hi_k1   = 16'h0;
        @(negedge Clk);
        OpA = a; OpB = b; SignMode = sm; Start = 1'b1;
        @(negedge Clk);
        // Scramble operands: they only need to be valid on the Start edge.
        Start = 1'b0; OpA = 16'hDEAD; OpB = 16'hBEEF; SignMode = ~sm;
        for (int k = 1; k <= 26; k++) begin
            if (k > 1) @(negedge Clk);
            if (k == 1) begin
                lo_k1 = ALUB_input3;
                hi_k1 = MultHi;
            end
            if (Busy) busy_n++;
            if (Done) begin
                done_n++;
                done_at = k;
                lo      = ALUB_input3;
                hi      = MultHi;
            end
            if (extra_starts) begin
                if (k == 5 || k == 18) begin
                    Start = 1'b1; OpA = 16'hFFFF; OpB = 16'hFFFF;
                end else begin
                    Start = 1'b0;
                end
            end
            if (reset_at > 0 && k == reset_at) Reset = 1'b1;
            if (reset_at > 0 && k == reset_at + 1) begin
                check("abort_busy", {31'd0, Busy}, 32'd0);
                check("abort_out", {MultHi, ALUB_input3}, 32'd0);
                Reset = 1'b0;
            end
        end
        Start = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [15:0] a,
                             input logic [15:0] b, input logic sm,
                             input logic [31:0] expected);
        logic [15:0] lo, hi, lo_k1, hi_k1;
        int busy_n, done_n, done_at;
        run_mult(a, b, sm, 1'b0, 0, lo, hi, lo_k1, hi_k1, busy_n, done_n, done_at);
        check({tag, "_done_n"}, done_n, 32'd1);
        check({tag, "_prod"}, {hi, lo}, expected);
    endtask

    initial begin
        logic [15:0] lo, hi, lo_k1, hi_k1;
        int busy_n, done_n, done_at;

        Reset = 1'b1; Start = 1'b0; SignMode = 1'b0; OpA = '0; OpB = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_out", {MultHi, ALUB_input3}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        check("idle_busy", {31'd0, Busy}, 32'd0);

        // 3 x 5 with full timing checks
        run_mult(16'd3, 16'd5, 1'b0, 1'b0, 0, lo, hi, lo_k1, hi_k1, busy_n, done_n, done_at);
        check("m35_done_n", done_n, 32'd1);
        check("m35_done_at", done_at, 32'd18);
        check("m35_busy_n", busy_n, 32'd18);
        check("m35_prod", {hi, lo}, 32'h0000_000F);

        // All-ones unsigned; outputs must still hold 3x5 while running
        run_mult(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0, lo, hi, lo_k1, hi_k1, busy_n, done_n, done_at);
        check("ff_hold_prev", {hi_k1, lo_k1}, 32'h0000_000F);
        check("ff_busy_n", busy_n, 32'd18);
        check("ff_done_at", done_at, 32'd18);
        check("ff_prod", {hi, lo}, 32'hFFFE_0001);

        // Carry into the high word, then hold for 10 idle cycles
        check_run("m100", 16'h0100, 16'h0100, 1'b0, 32'h0001_0000);
        repeat (10) @(negedge Clk);
        check("m100_hold", {MultHi, ALUB_input3}, 32'h0001_0000);
        check("m100_hold_busy", {31'd0, Busy}, 32'd0);

        check_run("m1234", 16'h1234, 16'h5678, 1'b0, 32'h0626_0060);
        check_run("m_zero", 16'h0000, 16'hABCD, 1'b0, 32'h0000_0000);

        // Signed mode
`ifdef CR16_MULT_SIGNED_EN
        check_run("s_m2x3", 16'hFFFE, 16'h0003, 1'b1, 32'hFFFF_FFFA);
        check_run("s_min", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        check_run("s_m3xm5", 16'hFFFD, 16'hFFFB, 1'b1, 32'h0000_000F);
        check_run("s_off", 16'hFFFE, 16'h0003, 1'b0, 32'h0002_FFFA);
`else
        check_run("s_m2x3", 16'hFFFE, 16'h0003, 1'b1, 32'h0002_FFFA);
        check_run("s_min", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        check_run("s_m3xm5", 16'hFFFD, 16'hFFFB, 1'b1, 32'hFFF8_000F);
`endif

        // Start pulses at E5 and on the Done cycle are ignored
        run_mult(16'h1234, 16'h5678, 1'b0, 1'b1, 0, lo, hi, lo_k1, hi_k1, busy_n, done_n, done_at);
        check("ign_done_n", done_n, 32'd1);
        check("ign_done_at", done_at, 32'd18);
        check("ign_busy_n", busy_n, 32'd18);
        check("ign_prod", {hi, lo}, 32'h0626_0060);

        // Reset sampled at E8 aborts the multiply: no Done, outputs cleared
        run_mult(16'd7, 16'd9, 1'b0, 1'b0, 8, lo, hi, lo_k1, hi_k1, busy_n, done_n, done_at);
        check("abort_hold_prev", {hi_k1, lo_k1}, 32'h0626_0060);
        check("abort_done_n", done_n, 32'd0);
        check("abort_busy_n", busy_n, 32'd8);
        check("abort_final", {MultHi, ALUB_input3}, 32'd0);

        // Unit recovers after the abort
        check_run("recover", 16'd7, 16'd9, 1'b0, 32'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cr16_mult_unit.md
# cr16_mult_unit

Sequential 16×16 shift-add multiplier for the CR16 processor. Sits directly upstream of the ALU B-operand mux and drives the mux's third input (`ALUB_input3`) with the low product word. The control FSM launches it with a one-cycle `Start` pulse. The FSM holds the pipeline while `Busy` is high, then selects mux input 3 on `Done`.

## Interface
Parameters:
- `WIDTH`, 16: operand width; product is 2·`WIDTH`.

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  rising-edge clock
- `Reset`  in  1  synchronous, active-high reset
- `Start`  in  1  launch request; sampled only in IDLE
- `SignMode`  in  1  1 = signed (two's complement) multiply; honoured only with `CR16_MULT_SIGNED_EN`
- `OpA`  in  `WIDTH`  multiplicand (Rsrc)
- `OpB`  in  `WIDTH`  multiplier (Rdest)
- `Busy`  out  1  high whenever state ≠ IDLE
- `Done`  out  1  one-cycle pulse; product valid
- `ALUB_input3`  out  `WIDTH`  product[15:0]; feeds ALU B mux input 3
- `MultHi`  out  `WIDTH`  product[31:16]

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE:
  - `Start`=1 latches `OpA`, `OpB` (and `SignMode`), clears the 32-bit accumulator, sets iteration count to 0, and moves to RUN.
  - `Start`=0 stays in IDLE.
- RUN, per cycle:
  - If multiplier LSB = 1, add the zero-extended multiplicand into accumulator[31:16] with carry kept in a 33rd bit.
  - Shift {carry, acc} right by 1; shift the multiplier right by 1.
  - After 16 iterations (count 0..15), move to DONE.
- DONE:
  - Register the product onto `ALUB_input3`/`MultHi` and assert `Done` for one cycle.
  - Return to IDLE unconditionally.
- Outputs hold the last product until the next DONE. They are not cleared by a new `Start`.
- `Start` while `Busy` is ignored; no queueing.
- `Start` on the same cycle `Done` is high is ignored (state is DONE). It is accepted the following cycle.
- Product is exact modulo 2^32; no overflow flag.

## Timing
- Reset: state IDLE; `Busy`=0, `Done`=0, `ALUB_input3`=0, `MultHi`=0; count and accumulator 0.
- Reset mid-RUN or mid-DONE aborts the operation. The in-flight product is discarded and `Done` does not pulse.
- Latency: `Start` sampled at edge E0.
  - `Busy` is high after E0 through the cycle following E17.
  - RUN occupies E1–E16.
  - DONE is entered at E17: product visible and `Done`=1 in the cycle after E17.
  - IDLE is re-entered at E18.
- Total: 18 cycles from Start edge to IDLE; issue interval 18 cycles.
- Operands need only be stable in the cycle `Start` is sampled.

## Configuration
- Macro `CR16_MULT_SIGNED_EN`.
- Defined:
  - With `SignMode`=1, operands are converted to magnitudes at latch time.
  - The sign flag is the XOR of both operand MSBs.
  - In DONE the 32-bit magnitude is two's-complement negated if the flag is set.
  - Latency is unchanged.
- Undefined: `SignMode` is ignored and every multiply is unsigned. No negation logic is built.

## Structure
- Shared package `cr16_pkg` holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - `CR16_WORD` width constant (16)
  - iteration count constant (16)
- Single module, no sub-modules. The FSM, 5-bit counter and datapath are inline; the datapath is too small to justify a split.

## Test plan
- Reset held 3 cycles, then released: all outputs 0, `Busy`=0. `Start` with `OpA`=3, `OpB`=5 → `Done` one cycle after E17, `ALUB_input3`=0x000F, `MultHi`=0x0000.
- Unsigned `OpA`=0xFFFF, `OpB`=0xFFFF → `MultHi`=0xFFFE, `ALUB_input3`=0x0001; `Busy` high for exactly 18 cycles.
- `OpA`=0x0100, `OpB`=0x0100 → `ALUB_input3`=0x0000, `MultHi`=0x0001. Outputs then hold for 10 idle cycles.
- With `CR16_MULT_SIGNED_EN`, `SignMode`=1:
  - −2 × 3 → 0xFFFF/0xFFFA (hi/lo).
  - 0x8000 × 0x8000 → 0x4000/0x0000.
  - Without the macro, the same −2 × 3 → 0x0002/0xFFFA.
- `Start` pulses at E5 and on the `Done` cycle are both ignored (single `Done`, result of first operands). `Reset` at E8 of a second multiply → IDLE, outputs 0, no `Done` pulse.
